// File: rtl/ahb5_slave_mem_if.sv
// ahb5_slave_mem_if: AHB5 bus signals between a master and the memory subordinate
interface ahb5_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  Hsel;
  logic [ADDR_WIDTH-1:0] Haddr;
  logic [1:0]            Htrans;
  logic                  Hwrite;
  logic [2:0]            Hsize;
  logic [2:0]            Hburst;
  logic [DATA_WIDTH-1:0] Hwdata;
  logic                  Hready;
  logic                  Hreadyout;
  logic                  Hresp;
  logic [DATA_WIDTH-1:0] Hrdata;
  modport master (output Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hready,
                  input Hreadyout, Hresp, Hrdata);
  modport slave (input Hsel, Haddr, Htrans, Hwrite, Hsize, Hburst, Hwdata, Hready,
                 output Hreadyout, Hresp, Hrdata);
endinterface

// File: rtl/ahb5_slave_mem.sv
// ahb5_slave_mem: AHB5 subordinate memory with wait states, two-cycle ERROR and write-to-read forwarding
module ahb5_slave_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input logic Hclk,
  input logic HReset,
  ahb5_slave_mem_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LNB = $clog2(NB);
  localparam int MW  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_DEPTH * NB);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;
  state_t                r_state, w_state_n;
  logic [3:0]            r_cnt, w_cnt_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write, r_pend;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [ADDR_WIDTH-1:0] w_off, w_roff, w_lane;
  logic [MW-1:0]         w_cidx, w_ridx;
  logic                  w_err, w_rdy, w_cap, w_commit, w_unused;
  logic [DATA_WIDTH-1:0] w_merged, w_fetch;
  // Below-base addresses wrap to a huge offset, so one compare covers both range ends
  assign w_off    = bus.Haddr - BASE_ADDR;
  assign w_roff   = r_addr - BASE_ADDR;
  assign w_cidx   = w_off[LNB +: MW];
  assign w_ridx   = w_roff[LNB +: MW];
  assign w_lane   = r_addr & ADDR_WIDTH'(NB - 1);
  assign w_err    = (w_off >= SPAN) | (bus.Hsize > 3'(LNB)) |
                    (|(bus.Haddr & ~({ADDR_WIDTH{1'b1}} << bus.Hsize)));
  assign w_rdy    = (r_state == S_WAIT) ? (r_cnt == 4'd0) : (r_state != S_ERR1);
  assign w_cap    = bus.Hsel & bus.Hready & bus.Htrans[1] & w_rdy;
  assign w_commit = w_rdy & r_pend & r_write;
  assign w_fetch  = (w_commit && w_cidx == w_ridx) ? w_merged : r_mem[w_cidx];
  assign w_unused = ^{bus.Hburst, w_off, w_roff};
  assign bus.Hreadyout = w_rdy;
  assign bus.Hresp     = (r_state == S_ERR1) | (r_state == S_ERR2);
  assign bus.Hrdata    = r_rdata;
  always_comb begin
    w_merged = r_mem[w_ridx];
    for (int b = 0; b < NB; b++)
      if (ADDR_WIDTH'(b) - w_lane < (ADDR_WIDTH'(1) << r_size)) w_merged[8*b +: 8] = bus.Hwdata[8*b +: 8];
  end
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (r_state == S_ERR1) w_state_n = S_ERR2;
    else if (w_rdy) w_state_n = !w_cap ? S_IDLE : w_err ? S_ERR1 : (WAIT_STATES == 0) ? S_IDLE : S_WAIT;
    if (w_cap && !w_err) w_cnt_n = 4'(WAIT_STATES);
    else if (r_state == S_WAIT && r_cnt != 4'd0) w_cnt_n = r_cnt - 4'd1;
  end
  always_ff @(posedge Hclk) begin
    if (HReset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      if (w_rdy) r_pend <= w_cap & ~w_err;
      if (w_cap) begin
        r_addr  <= bus.Haddr;
        r_write <= bus.Hwrite;
        r_size  <= bus.Hsize;
      end
      // Zero-wait reads fetch at capture; waited reads fetch on the last low cycle
      if (w_cap && w_err) r_rdata <= '0;
      else if (w_cap && !bus.Hwrite && WAIT_STATES == 0) r_rdata <= w_fetch;
      else if (r_state == S_WAIT && r_cnt == 4'd1 && r_pend && !r_write) r_rdata <= r_mem[w_ridx];
    end
  end
  always_ff @(posedge Hclk) begin
    if (!HReset && w_commit) r_mem[w_ridx] <= w_merged;
  end
endmodule

// File: tb/tb_ahb5_slave_mem.sv
// tb_ahb5_slave_mem: scoreboard bench driving a zero-wait and a two-wait instance through one pipelined driver
module tb_ahb5_slave_mem;
  typedef struct {logic [31:0] addr; logic write; logic [2:0] size; logic [31:0] wdata;} xfer_t;
  typedef struct {string name; logic resp; logic chk; logic [31:0] data; int waits;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  xfer_t stim[$];
  exp_t  sb[$];
  xfer_t ap;
  int tests = 0, fails = 0, waits = 0;
  logic dut = 1'b0, sel = 1'b0, wr = 1'b0;
  logic [1:0] trans = 2'b00;
  logic [2:0] size = 3'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic rst_seen = 1'b1, rdy_n = 1'b1, in_dp = 1'b0, ap_valid = 1'b0;
  logic m_rdy, m_resp;
  logic [31:0] m_rdata;
  ahb5_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if0 ();
  ahb5_slave_mem_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if1 ();
  assign if0.Hsel = sel & ~dut;
  assign if1.Hsel = sel & dut;
  assign if0.Haddr = addr;
  assign if1.Haddr = addr;
  assign if0.Htrans = trans;
  assign if1.Htrans = trans;
  assign if0.Hwrite = wr;
  assign if1.Hwrite = wr;
  assign if0.Hsize = size;
  assign if1.Hsize = size;
  assign if0.Hburst = 3'b000;
  assign if1.Hburst = 3'b000;
  assign if0.Hwdata = wdata;
  assign if1.Hwdata = wdata;
  assign if0.Hready = if0.Hreadyout;
  assign if1.Hready = if1.Hreadyout;
  assign m_rdy   = dut ? if1.Hreadyout : if0.Hreadyout;
  assign m_resp  = dut ? if1.Hresp : if0.Hresp;
  assign m_rdata = dut ? if1.Hrdata : if0.Hrdata;
  ahb5_slave_mem #(.WAIT_STATES(0)) u0 (.Hclk(clk), .HReset(rst), .bus(if0));
  ahb5_slave_mem #(.WAIT_STATES(2)) u1 (.Hclk(clk), .HReset(rst), .bus(if1));

  task automatic check(string n, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h need %h", n, act, req);
    end
  endtask

  task automatic issue(string n, logic [31:0] a, logic w, logic [2:0] s, logic [31:0] d,
                       logic er, logic [31:0] rd, int wt);
    xfer_t x;
    exp_t e;
    x.addr = a; x.write = w; x.size = s; x.wdata = d;
    e.name = n; e.resp = er; e.chk = !w; e.data = rd; e.waits = wt;
    stim.push_back(x);
    sb.push_back(e);
  endtask

  task automatic drain();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      ok = stim.size() == 0 && sb.size() == 0 && !ap_valid && !in_dp;
    end
    check("drain", {31'd0, ok}, 32'd1);
  endtask

  always @(posedge clk) rst_seen <= rst;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst_seen) begin
        ap_valid = 1'b0; sel = 1'b0; trans = 2'b00;
      end else if (rdy_n) begin
        if (ap_valid && ap.write) wdata = ap.wdata;
        ap_valid = stim.size() > 0;
        if (ap_valid) ap = stim.pop_front();
        sel = ap_valid; trans = ap_valid ? 2'b10 : 2'b00;
        addr = ap.addr; wr = ap.write; size = ap.size;
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      rdy_n = m_rdy;
      if (rst_seen) begin
        in_dp = 1'b0; waits = 0;
      end else if (in_dp && !m_rdy) waits++;
      else begin
        if (in_dp) begin
          if (sb.size() == 0) check("unexpected completion", 32'd1, 32'd0);
          else begin
            e = sb.pop_front();
            check({e.name, " resp"}, {31'd0, m_resp}, {31'd0, e.resp});
            check({e.name, " waits"}, 32'(waits), 32'(e.waits));
            if (e.chk) check({e.name, " data"}, m_rdata, e.data);
          end
          waits = 0;
        end
        in_dp = sel && trans[1] && m_rdy;
      end
    end
  end

  initial begin
    logic hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst rdy0", {31'd0, if0.Hreadyout}, 32'd1);
    check("rst resp0", {31'd0, if0.Hresp}, 32'd0);
    check("rst rdata0", if0.Hrdata, 32'd0);
    check("rst rdy1", {31'd0, if1.Hreadyout}, 32'd1);
    check("rst resp1", {31'd0, if1.Hresp}, 32'd0);
    check("rst rdata1", if1.Hrdata, 32'd0);
    rst = 1'b0;
    issue("w10", 32'h10, 1, 3'd2, 32'hDEADBEEF, 0, 0, 0);
    issue("r10 fwd", 32'h10, 0, 3'd2, 0, 0, 32'hDEADBEEF, 0);
    drain();
    issue("w10b", 32'h10, 1, 3'd2, 32'h11223344, 0, 0, 0);
    issue("wbyte13", 32'h13, 1, 3'd0, 32'hAA555555, 0, 0, 0);
    issue("r10 byte", 32'h10, 0, 3'd2, 0, 0, 32'hAA223344, 0);
    drain();
    issue("w0", 32'h0, 1, 3'd2, 32'h01020304, 0, 0, 0);
    issue("w oob", 32'h1000, 1, 3'd2, 32'hFFFFFFFF, 1, 0, 1);
    issue("r0 after oob", 32'h0, 0, 3'd2, 0, 0, 32'h01020304, 0);
    issue("r oob", 32'h1000, 0, 3'd2, 0, 1, 32'h0, 1);
    drain();
    issue("w half mis", 32'h1, 1, 3'd1, 32'hFFFFFFFF, 1, 0, 1);
    issue("r0 after mis", 32'h0, 0, 3'd2, 0, 0, 32'h01020304, 0);
    issue("r size8", 32'h0, 0, 3'd3, 0, 1, 32'h0, 1);
    issue("w half2", 32'h2, 1, 3'd1, 32'hBEEF5555, 0, 0, 0);
    issue("r half2", 32'h2, 0, 3'd1, 0, 0, 32'hBEEF0304, 0);
    drain();
    dut = 1'b1;
    issue("ws w4", 32'h4, 1, 3'd2, 32'hCAFEF00D, 0, 0, 2);
    issue("ws r4", 32'h4, 0, 3'd2, 0, 0, 32'hCAFEF00D, 2);
    issue("ws r oob", 32'h2000, 0, 3'd2, 0, 1, 32'h0, 1);
    drain();
    stim.push_back('{addr: 32'h4, write: 1'b1, size: 3'd2, wdata: 32'h12345678});
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      hit = !m_rdy;
    end
    check("ws wait seen", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst rdy", {31'd0, m_rdy}, 32'd1);
    check("mid rst resp", {31'd0, m_resp}, 32'd0);
    rst = 1'b0;
    issue("r4 after rst", 32'h4, 0, 3'd2, 0, 0, 32'hCAFEF00D, 2);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, need completion");
    $fatal(1);
  end
endmodule
